// File: rtl/decode_controller_pkg.sv
// ---------------------------------------------------------------------------
// decode_controller_pkg
//
// Purpose:
//   Definitions shared by the receive-side (decode) and send-side (encode)
//   router controllers. Both directions agree on one controller state
//   encoding and on one DFX word layout {payload, dst_addr}. The address
//   field sits at the bottom of the word and the payload directly above it.
//
// Contents:
//   ctrl_state_e   - 3-bit controller state encoding
//   ADDR_LSB       - bit position of dst_addr inside a DFX word
//   DATA_LSB       - bit position of the payload for the default address width
//   dfx_data_lsb() - payload position for an arbitrary address width
// ---------------------------------------------------------------------------
package decode_controller_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        CHECK         = 3'd1,
        WRITE_ARBITER = 3'd2,
        DONE          = 3'd3,
        DROP          = 3'd4
    } ctrl_state_e;

    localparam int DFX_ADDR_WIDTH = 10;
    localparam int ADDR_LSB       = 0;
    localparam int DATA_LSB       = ADDR_LSB + DFX_ADDR_WIDTH;

    // Payload starts right above the address field, whatever its width.
    function automatic int dfx_data_lsb(input int addr_width);
        return ADDR_LSB + addr_width;
    endfunction

endpackage

// File: rtl/decode_controller.sv
// ---------------------------------------------------------------------------
// decode_controller
//
// Purpose:
//   Receive-side router controller. Accepts decoded DFX words from the
//   decode-packet block and writes the payload into local memory through the
//   arbiter write port. When the packet has been written it pulses
//   router_recv_done and increments recv_pkt_cnt. A packet whose address is
//   outside local memory, or whose write is never granted within GNT_TIMEOUT
//   request cycles, is dropped with a router_recv_err pulse.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   router_recv_en      - level enable from the total controller
//   router_recv_done    - 1-cycle pulse, packet written
//   router_recv_err     - 1-cycle pulse, packet dropped
//   recv_pkt_cnt        - delivered packet count (wraps)
//   decode_valid        - decoded word valid
//   ready_decode_pkt    - controller can accept a decoded word
//   data_dfx_recv       - decoded word {payload, dst_addr}
//   arbiter_write_req   - write request; committed in the cycle req && gnt
//   arbiter_write_gnt   - arbiter grant
//   arbiter_dst_addr    - write address (qualified by req)
//   data_arbiter_write  - write payload (qualified by req)
//
// Every output comes straight from a flop, so there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module decode_controller
    import decode_controller_pkg::*;
#(
    parameter int DATA_WIDTH     = 1024,
    parameter int ADDR_WIDTH     = DFX_ADDR_WIDTH,
    parameter int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH,
    parameter int MEM_DEPTH      = 1024,
    parameter int GNT_TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      router_recv_en,
    output logic                      router_recv_done,
    output logic                      router_recv_err,
    output logic [15:0]               recv_pkt_cnt,
    input  logic                      decode_valid,
    output logic                      ready_decode_pkt,
    input  logic [DATA_DFX_WIDTH-1:0] data_dfx_recv,
    output logic                      arbiter_write_req,
    input  logic                      arbiter_write_gnt,
    output logic [ADDR_WIDTH-1:0]     arbiter_dst_addr,
    output logic [DATA_WIDTH-1:0]     data_arbiter_write
);

    localparam int PAYLOAD_LSB = dfx_data_lsb(ADDR_WIDTH);
    localparam int TMO_W       = $clog2(GNT_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GNT_TIMEOUT - 1);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  req_q, req_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic                  addr_in_range;

    // A handshake happens only against the ready value the decoder actually sees.
    assign accept = (state_q == IDLE) && ready_q && decode_valid;

    // Widened compare so that MEM_DEPTH == 2**ADDR_WIDTH is simply always true.
    assign addr_in_range = (32'(addr_q) < 32'(MEM_DEPTH));

    // Next-state and capture logic. Capture happens only on an accepted
    // handshake, so a word offered while disabled leaves the registers alone.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = data_dfx_recv[ADDR_LSB +: ADDR_WIDTH];
                    data_d  = data_dfx_recv[PAYLOAD_LSB +: DATA_WIDTH];
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = addr_in_range ? WRITE_ARBITER : DROP;
            end
            WRITE_ARBITER: begin
                // A grant on the final allowed cycle still wins.
                if (arbiter_write_gnt) begin
                    state_d = DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = DROP;
                end
            end
            DONE:    state_d = IDLE;
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant-wait counter: cleared on the way into the request phase and
    // advanced on each ungranted request cycle.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == CHECK) begin
            tmo_d = '0;
        end else if (state_q == WRITE_ARBITER && !arbiter_write_gnt && tmo_q != TMO_LAST) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // Outputs are computed from the next state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        ready_d = (state_d == IDLE) && router_recv_en;
        req_d   = (state_d == WRITE_ARBITER);
        done_d  = (state_d == DONE);
        err_d   = (state_d == DROP);
        cnt_d   = done_d ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ready_decode_pkt   = ready_q;
    assign arbiter_write_req  = req_q;
    assign router_recv_done   = done_q;
    assign router_recv_err    = err_q;
    assign recv_pkt_cnt       = cnt_q;
    assign arbiter_dst_addr   = addr_q;
    assign data_arbiter_write = data_q;

endmodule

// File: tb/tb_decode_controller.sv
// ---------------------------------------------------------------------------
// tb_decode_controller
//
// Directed and randomized packets against decode_controller. The expected
// behaviour of each packet is derived up front from its address and grant
// delay: whether it is delivered, how many request cycles it takes, and
// the resulting delivered count.
// ---------------------------------------------------------------------------
module tb_decode_controller;

    localparam int DW   = 64;
    localparam int AW   = 10;
    localparam int DFXW = DW + AW;
    localparam int MD   = 512;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            router_recv_en;
    logic            router_recv_done;
    logic            router_recv_err;
    logic [15:0]     recv_pkt_cnt;
    logic            decode_valid;
    logic            ready_decode_pkt;
    logic [DFXW-1:0] data_dfx_recv;
    logic            arbiter_write_req;
    logic            arbiter_write_gnt;
    logic [AW-1:0]   arbiter_dst_addr;
    logic [DW-1:0]   data_arbiter_write;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] expCnt = 16'd0;
    logic [AW-1:0] lastAddr = '0;
    logic [DW-1:0] lastData = '0;

    decode_controller #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .DATA_DFX_WIDTH(DFXW),
        .MEM_DEPTH     (MD),
        .GNT_TIMEOUT   (TMO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .router_recv_en    (router_recv_en),
        .router_recv_done  (router_recv_done),
        .router_recv_err   (router_recv_err),
        .recv_pkt_cnt      (recv_pkt_cnt),
        .decode_valid      (decode_valid),
        .ready_decode_pkt  (ready_decode_pkt),
        .data_dfx_recv     (data_dfx_recv),
        .arbiter_write_req (arbiter_write_req),
        .arbiter_write_gnt (arbiter_write_gnt),
        .arbiter_dst_addr  (arbiter_dst_addr),
        .data_arbiter_write(data_arbiter_write)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic en, input logic valid, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic gnt);
        router_recv_en    = en;
        decode_valid      = valid;
        data_dfx_recv     = {data, addr};
        arbiter_write_gnt = gnt;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, 64'(ready_decode_pkt), 64'd0);
        checkOutput({tag, "_req"},   64'(arbiter_write_req), 64'd0);
        checkOutput({tag, "_done"},  64'(router_recv_done), 64'd0);
        checkOutput({tag, "_err"},   64'(router_recv_err), 64'd0);
        checkOutput({tag, "_cnt"},   64'(recv_pkt_cnt), 64'd0);
        checkOutput({tag, "_addr"},  64'(arbiter_dst_addr), 64'd0);
        checkOutput({tag, "_data"},  64'(data_arbiter_write), 64'd0);
    endtask

    // Offers one word and follows it to completion. Entered and left just
    // after a falling edge. gntDelay is the number of ungranted request
    // cycles before the grant; gntDelay >= TMO means the grant never comes.
    task automatic sendPacket(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input int gntDelay, input bit tieGnt, input bit dropEn);
        bit bad;
        bit delivered;
        int reqCycles;
        int waitCnt;
        bad       = (int'(addr) >= MD);
        delivered = !bad && (tieGnt || gntDelay < TMO);
        if (bad)            reqCycles = 0;
        else if (tieGnt)    reqCycles = 1;
        else if (delivered) reqCycles = gntDelay + 1;
        else                reqCycles = TMO;
        waitCnt = 0;

        applyStimulus(router_recv_en, 1'b1, addr, data, tieGnt ? 1'b1 : 1'($urandom_range(0, 1)));
        while (ready_decode_pkt !== 1'b1 && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (ready_decode_pkt !== 1'b1) begin
            checkOutput("accept_wait", 64'(ready_decode_pkt), 64'd1);
            decode_valid = 1'b0;
            return;
        end
        lastAddr = addr;
        lastData = data;

        @(negedge clk);
        applyStimulus(router_recv_en, 1'b0, addr, data, tieGnt ? 1'b1 : 1'($urandom_range(0, 1)));
        checkOutput("chk_req",   64'(arbiter_write_req), 64'd0);
        checkOutput("chk_ready", 64'(ready_decode_pkt), 64'd0);
        checkOutput("chk_done",  64'(router_recv_done), 64'd0);
        checkOutput("chk_err",   64'(router_recv_err), 64'd0);
        checkOutput("chk_addr",  64'(arbiter_dst_addr), 64'(addr));

        @(negedge clk);
        for (int k = 0; k < reqCycles; k++) begin
            checkOutput("wr_req",   64'(arbiter_write_req), 64'd1);
            checkOutput("wr_addr",  64'(arbiter_dst_addr), 64'(addr));
            checkOutput("wr_data",  64'(data_arbiter_write), 64'(data));
            checkOutput("wr_done",  64'(router_recv_done), 64'd0);
            checkOutput("wr_err",   64'(router_recv_err), 64'd0);
            checkOutput("wr_ready", 64'(ready_decode_pkt), 64'd0);
            if (dropEn && k == 0) router_recv_en = 1'b0;
            arbiter_write_gnt = tieGnt || (k == gntDelay);
            @(negedge clk);
        end

        if (delivered) expCnt++;
        checkOutput("end_done", 64'(router_recv_done), 64'(delivered));
        checkOutput("end_err",  64'(router_recv_err), 64'(!delivered));
        checkOutput("end_req",  64'(arbiter_write_req), 64'd0);
        checkOutput("end_cnt",  64'(recv_pkt_cnt), 64'(expCnt));
        arbiter_write_gnt = tieGnt ? 1'b1 : 1'($urandom_range(0, 1));

        @(negedge clk);
        checkOutput("idle_done",  64'(router_recv_done), 64'd0);
        checkOutput("idle_err",   64'(router_recv_err), 64'd0);
        checkOutput("idle_req",   64'(arbiter_write_req), 64'd0);
        checkOutput("idle_ready", 64'(ready_decode_pkt), 64'(router_recv_en));
        checkOutput("idle_cnt",   64'(recv_pkt_cnt), 64'(expCnt));
    endtask

    initial begin
        logic [AW-1:0] rAddr;
        logic [DW-1:0] rData;

        $display("[TB] decode_controller bench start");
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        checkAllZero("reset");

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        @(negedge clk);

        // Basic delivery with the grant tied high.
        sendPacket(10'h03C, {8{8'hA5}}, 0, 1'b1, 1'b0);
        // Grant after five ungranted request cycles.
        sendPacket(10'h101, 64'h0123_4567_89AB_CDEF, 5, 1'b0, 1'b0);
        // Grant never arrives: eight request cycles then a drop.
        sendPacket(10'h0F0, 64'hDEAD_BEEF_0000_1111, TMO + 3, 1'b0, 1'b0);
        // Grant on the last allowed cycle.
        sendPacket(10'h0F1, 64'hCAFE_F00D_2222_3333, TMO - 1, 1'b0, 1'b0);
        // Out-of-range addresses, first one just past the end.
        sendPacket(10'h200, 64'h5555_AAAA_5555_AAAA, 0, 1'b1, 1'b0);
        sendPacket(10'h3FF, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1'b0, 1'b0);
        // Last valid address.
        sendPacket(10'h1FF, 64'hFFFF_0000_FFFF_0000, 2, 1'b0, 1'b0);

        // Disabled receive path: the offered word must not be captured.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 10'h055, 64'h1357_9BDF_2468_ACE0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("dis_ready", 64'(ready_decode_pkt), 64'd0);
            checkOutput("dis_req",   64'(arbiter_write_req), 64'd0);
            checkOutput("dis_addr",  64'(arbiter_dst_addr), 64'(lastAddr));
            checkOutput("dis_data",  64'(data_arbiter_write), 64'(lastData));
        end
        router_recv_en = 1'b1;
        @(negedge clk);
        checkOutput("en_ready", 64'(ready_decode_pkt), 64'd1);
        sendPacket(10'h055, 64'h1357_9BDF_2468_ACE0, 1, 1'b0, 1'b0);

        // Enable dropped while the write is pending: the packet still completes.
        sendPacket(10'h077, 64'h7777_8888_9999_AAAA, 3, 1'b0, 1'b1);
        router_recv_en = 1'b1;
        @(negedge clk);

        // Randomized packets.
        for (int n = 0; n < 24; n++) begin
            rAddr = ($urandom_range(0, 3) == 0) ? AW'(MD + $urandom_range(0, 511))
                                                : AW'($urandom_range(0, MD - 1));
            rData = {$urandom, $urandom};
            sendPacket(rAddr, rData, int'($urandom_range(0, TMO + 2)), 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset while a write request is pending.
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_ready", 64'(ready_decode_pkt), 64'd1);
        applyStimulus(1'b1, 1'b1, 10'h1F0, 64'hBBBB_CCCC_DDDD_EEEE, 1'b0);
        @(negedge clk);
        decode_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_req", 64'(arbiter_write_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_mid");
        @(negedge clk);
        checkAllZero("rst_hold");
        rst_n    = 1'b1;
        expCnt   = 16'd0;
        lastAddr = '0;
        lastData = '0;
        @(negedge clk);
        checkOutput("post_rst_ready", 64'(ready_decode_pkt), 64'd1);
        checkOutput("post_rst_done",  64'(router_recv_done), 64'd0);
        checkOutput("post_rst_err",   64'(router_recv_err), 64'd0);
        sendPacket(10'h03C, {8{8'hA5}}, 0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
